bcd_score_up: RTL and testbench
===============================

# bcd_score_up

BCD up-accumulator for the game score: adds a two-digit BCD amount (0–99) per request to a three-digit BCD total (000–999), one digit per clock. It complements the bomb/timer BCD down counters: those count a loaded value down to a terminal count, while this block counts up from zero and saturates at 999. It sits between the hit/collision logic (request source) and the score display digits.

## Interface
- No parameters. Limits are package constants.
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- loadN  in  1  synchronous clear, active low: total, flags, pending entry and FSM return to zero/IDLE
- add_req  in  1  one-cycle request to add add_val
- add_val  in  8  BCD amount: [7:4] tens, [3:0] units
- countL  out  4  committed units digit
- countM  out  4  committed tens digit
- countH  out  4  committed hundreds digit
- busy  out  1  addition in progress
- done  out  1  one-cycle pulse on each commit
- sat  out  1  sticky: a commit saturated at 999
- dropped  out  1  sticky: a request was lost because the pending slot was full

## Operation
- The FSM has four states: IDLE, S_U (units), S_T (tens), S_H (hundreds).
- IDLE with add_req=1: latch add_val into the operand register, copy the committed digits into the working digits, then go to S_U.
- S_U: working units = units + operand units, with carry. Go to S_T.
- S_T: working tens = tens + operand tens + carry, with carry. Go to S_H.
- S_H: working hundreds = hundreds + carry.
  - If that sum is greater than 9, commit 9/9/9 and set sat.
  - Otherwise commit the working digits.
  - Pulse done. Then:
    - if the pending slot is valid: load its value into the operand register, copy the just-committed digits into the working digits, clear the slot, and go to S_U.
    - else: go to IDLE.
- A request in S_U/S_T/S_H, or in the S_H cycle itself:
  - If the pending slot is empty, store the value there.
  - Otherwise discard the request and set dropped.
  - This gives a one-entry buffer.
- Any operand digit greater than 9 is clamped to 9 when latched.
- Per-digit rule: s = a + b + cin (5 bits). If s > 9, digit = s − 10 and cout = 1; otherwise digit = s and cout = 0.
- The count outputs change only on a commit, so they are always a coherent 3-digit value.
- sat and dropped clear only on resetN or loadN.

## Timing
- Reset values: countL/M/H = 0, busy = 0, done = 0, sat = 0, dropped = 0, pending slot empty, FSM in IDLE.
- Request sampled at edge t in IDLE:
  - busy high after edge t.
  - Commit and done pulse after edge t+3.
  - The next request can be accepted at edge t+3 or later.
- Latency is 3 cycles from the accepting edge to the updated outputs. Throughput is one add per 3 cycles.
- busy is high throughout S_U/S_T/S_H. It does not drop between back-to-back additions served from the pending slot.
- loadN low at an edge overrides everything, including a concurrent add_req, and discards any in-flight addition.
- resetN asserted mid-operation: all outputs go to their reset values immediately (asynchronously).
- A total already at 999 with a further add: commits 999, sets sat, pulses done.

## Structure
- Package score_pkg holds:
  - the state enum typedef (IDLE, S_U, S_T, S_H)
  - BCD_MAX_DIGIT = 4'd9
  - the digit-width constant
- Sub-module bcd_digit_add: a combinational single-digit BCD adder (a, b, cin → digit, cout). It is shared by the three digit steps via a mux on the current state.
- The top level holds the FSM, the operand/working/committed registers, the pending slot and the sticky flags.

## Test plan
- Reset, then add 0x25 → after 3 cycles countH/M/L = 0/2/5, done pulses once, busy is low in the following cycle.
- Total 0/9/8, add 0x07 → 1/0/5 (carry ripples through two digits).
- Total 9/9/0, add 0x15 → 9/9/9 with sat = 1; a further add 0x01 → stays 999, sat stays 1.
- Add 0x10, a second request 0x05 while busy, and a third request 0x03 while the slot is full → final total 015, dropped = 1, busy continuous across the two commits.
- Assert loadN mid-addition together with add_req → total 000, FSM in IDLE, flags cleared, no done pulse.
- add_val = 0xAF → treated as 99; resetN pulsed during S_T → all outputs zero immediately.

Source files
------------

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared constants, state encoding and BCD helpers for the score accumulator.
//   DIGIT_W       : width of one BCD digit
//   BCD_MAX_DIGIT : largest legal BCD digit; also the saturation digit
//   state_e       : accumulator FSM states (IDLE, S_U units, S_T tens, S_H hundreds)
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S_U  = 2'd1,
    S_T  = 2'd2,
    S_H  = 2'd3
  } state_e;

  // Out-of-range digits (A..F) are treated as 9 so the adder only sees legal BCD.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] r;
    if (d > BCD_MAX_DIGIT) begin
      r = BCD_MAX_DIGIT;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Clamp both digits of a two-digit BCD amount.
  function automatic logic [2*DIGIT_W-1:0] clamp_amount(input logic [2*DIGIT_W-1:0] v);
    return {clamp_digit(v[2*DIGIT_W-1:DIGIT_W]), clamp_digit(v[DIGIT_W-1:0])};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder: digit_o/cout_o = a_i + b_i + cin_i.
//   a_i, b_i : BCD digits (0..9)
//   cin_i    : carry in
//   digit_o  : BCD result digit
//   cout_o   : decimal carry out (sum exceeded 9)
// -----------------------------------------------------------------------------
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  logic [DIGIT_W:0] sum_s;

  // Binary sum followed by decimal correction.
  always_comb begin
    sum_s   = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
    digit_o = sum_s[DIGIT_W-1:0];
    cout_o  = 1'b0;
    if (sum_s > 5'd9) begin
      // Modulo-16 subtraction gives the right digit for sums 10..19.
      digit_o = sum_s[DIGIT_W-1:0] - 4'd10;
      cout_o  = 1'b1;
    end else begin
      digit_o = sum_s[DIGIT_W-1:0];
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_score_up.sv
// -----------------------------------------------------------------------------
// bcd_score_up
// Three-digit BCD score accumulator, one digit per clock, saturating at 999,
// with a one-entry pending slot for requests arriving while busy.
//   clk      : system clock
//   resetN   : asynchronous active-low reset
//   loadN    : synchronous active-low clear (total, flags, slot, FSM)
//   add_req  : one-cycle request to add add_val
//   add_val  : BCD amount, [7:4] tens, [3:0] units (A..F digits clamp to 9)
//   countL/M/H : committed units/tens/hundreds digits
//   busy     : addition in progress
//   done     : one-cycle pulse per commit
//   sat      : sticky, a commit saturated at 999
//   dropped  : sticky, a request was lost because the slot was full
// -----------------------------------------------------------------------------
module bcd_score_up
  import score_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 loadN,
  input  logic                 add_req,
  input  logic [2*DIGIT_W-1:0] add_val,
  output logic [DIGIT_W-1:0]   countL,
  output logic [DIGIT_W-1:0]   countM,
  output logic [DIGIT_W-1:0]   countH,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic                 dropped
);

  state_e                 state_q;
  logic [2*DIGIT_W-1:0]   op_q;
  logic [DIGIT_W-1:0]     wu_q, wt_q, wh_q;
  logic                   carry_q;
  logic [DIGIT_W-1:0]     cl_q, cm_q, ch_q;
  logic                   busy_q, done_q, sat_q, drop_q;
  logic                   pend_v_q;
  logic [2*DIGIT_W-1:0]   pend_q;

  logic [DIGIT_W-1:0]     add_a_s, add_b_s, add_digit_s;
  logic                   add_cin_s, add_cout_s;
  logic [DIGIT_W-1:0]     cl_d, cm_d, ch_d;
  logic                   sat_hit_d;

  // Route the digit pair for the current step into the shared adder.
  always_comb begin
    add_a_s   = 4'd0;
    add_b_s   = 4'd0;
    add_cin_s = 1'b0;
    case (state_q)
      S_U: begin
        add_a_s   = wu_q;
        add_b_s   = op_q[DIGIT_W-1:0];
        add_cin_s = 1'b0;
      end
      S_T: begin
        add_a_s   = wt_q;
        add_b_s   = op_q[2*DIGIT_W-1:DIGIT_W];
        add_cin_s = carry_q;
      end
      S_H: begin
        add_a_s   = wh_q;
        add_b_s   = 4'd0;
        add_cin_s = carry_q;
      end
      default: begin
        add_a_s   = 4'd0;
        add_b_s   = 4'd0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  bcd_digit_add u_digit_add (
    .a_i     (add_a_s),
    .b_i     (add_b_s),
    .cin_i   (add_cin_s),
    .digit_o (add_digit_s),
    .cout_o  (add_cout_s)
  );

  // Commit value for the hundreds step: a carry out of hundreds means >999.
  always_comb begin
    sat_hit_d = add_cout_s;
    cl_d      = wu_q;
    cm_d      = wt_q;
    ch_d      = add_digit_s;
    if (add_cout_s) begin
      cl_d = BCD_MAX_DIGIT;
      cm_d = BCD_MAX_DIGIT;
      ch_d = BCD_MAX_DIGIT;
    end else begin
      cl_d = wu_q;
      cm_d = wt_q;
      ch_d = add_digit_s;
    end
  end

  // FSM, operand/working/committed registers, pending slot and sticky flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      op_q     <= 8'd0;
      wu_q     <= 4'd0;
      wt_q     <= 4'd0;
      wh_q     <= 4'd0;
      carry_q  <= 1'b0;
      cl_q     <= 4'd0;
      cm_q     <= 4'd0;
      ch_q     <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= 8'd0;
    end else if (!loadN) begin
      state_q  <= IDLE;
      op_q     <= 8'd0;
      wu_q     <= 4'd0;
      wt_q     <= 4'd0;
      wh_q     <= 4'd0;
      carry_q  <= 1'b0;
      cl_q     <= 4'd0;
      cm_q     <= 4'd0;
      ch_q     <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (add_req) begin
            op_q    <= clamp_amount(add_val);
            wu_q    <= cl_q;
            wt_q    <= cm_q;
            wh_q    <= ch_q;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_U;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        S_U: begin
          wu_q    <= add_digit_s;
          carry_q <= add_cout_s;
          state_q <= S_T;
        end
        S_T: begin
          wt_q    <= add_digit_s;
          carry_q <= add_cout_s;
          state_q <= S_H;
        end
        S_H: begin
          cl_q   <= cl_d;
          cm_q   <= cm_d;
          ch_q   <= ch_d;
          done_q <= 1'b1;
          if (sat_hit_d) begin
            sat_q <= 1'b1;
          end
          if (pend_v_q) begin
            // Chain straight into the buffered add; busy stays high.
            op_q     <= pend_q;
            wu_q     <= cl_d;
            wt_q     <= cm_d;
            wh_q     <= ch_d;
            carry_q  <= 1'b0;
            pend_v_q <= 1'b0;
            state_q  <= S_U;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // Requests while busy go to the slot. The slot state seen here is the
      // pre-edge one, so a request in S_H with a full slot is dropped even
      // though the slot is being drained in the same cycle.
      if (add_req && (state_q != IDLE)) begin
        if (!pend_v_q) begin
          pend_v_q <= 1'b1;
          pend_q   <= clamp_amount(add_val);
        end else begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  assign countL  = cl_q;
  assign countM  = cm_q;
  assign countH  = ch_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sat     = sat_q;
  assign dropped = drop_q;

endmodule

// File: tb/tb_bcd_score_up.sv
// -----------------------------------------------------------------------------
// tb_bcd_score_up
// Self-checking bench for bcd_score_up: a vector table of adds with
// hand-computed totals, plus hand-written sequences for the pending slot,
// loadN override and asynchronous reset. Expected commits are queued when a
// request is driven and checked by a monitor whenever done pulses.
// -----------------------------------------------------------------------------
module tb_bcd_score_up;

  logic       clk;
  logic       resetN;
  logic       loadN;
  logic       add_req;
  logic [7:0] add_val;
  logic [3:0] countL, countM, countH;
  logic       busy, done, sat, dropped;

  typedef struct {
    logic [11:0] total;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] total;
    logic        sat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int   n_cmp;
  int   n_fail;

  bcd_score_up dut (
    .clk     (clk),
    .resetN  (resetN),
    .loadN   (loadN),
    .add_req (add_req),
    .add_val (add_val),
    .countL  (countL),
    .countM  (countM),
    .countH  (countH),
    .busy    (busy),
    .done    (done),
    .sat     (sat),
    .dropped (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got total %0h with no commit expected at %0t",
                 {countH, countM, countL}, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("commit_total", int'({countH, countM, countL}), int'(e.total));
        chk("commit_sat", int'(sat), int'(e.sat));
      end
    end
  end

  // Single add from IDLE: checks busy, 3-cycle latency and the trailing idle cycle.
  task automatic run_add(input logic [7:0] v, input logic [11:0] exp_total, input logic exp_sat);
    int cyc;
    exp_t e;
    e.total = exp_total;
    e.sat   = exp_sat;
    sb_q.push_back(e);
    add_req = 1'b1;
    add_val = v;
    @(posedge clk); #1;
    add_req = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, 3);
    @(posedge clk); #1;
    chk("busy_after_commit", int'(busy), 0);
    chk("done_single_pulse", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    n_cmp   = 0;
    n_fail  = 0;
    resetN  = 1'b0;
    loadN   = 1'b1;
    add_req = 1'b0;
    add_val = 8'h00;

    vecs[0]  = '{8'h25, 12'h025, 1'b0};
    vecs[1]  = '{8'h73, 12'h098, 1'b0};
    vecs[2]  = '{8'h07, 12'h105, 1'b0};
    vecs[3]  = '{8'hAF, 12'h204, 1'b0};
    vecs[4]  = '{8'h99, 12'h303, 1'b0};
    vecs[5]  = '{8'h99, 12'h402, 1'b0};
    vecs[6]  = '{8'h99, 12'h501, 1'b0};
    vecs[7]  = '{8'h99, 12'h600, 1'b0};
    vecs[8]  = '{8'h90, 12'h690, 1'b0};
    vecs[9]  = '{8'h99, 12'h789, 1'b0};
    vecs[10] = '{8'h99, 12'h888, 1'b0};
    vecs[11] = '{8'h99, 12'h987, 1'b0};
    vecs[12] = '{8'h03, 12'h990, 1'b0};
    vecs[13] = '{8'h15, 12'h999, 1'b1};
    vecs[14] = '{8'h01, 12'h999, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_total", int'({countH, countM, countL}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sat", int'(sat), 0);
    chk("reset_dropped", int'(dropped), 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // Vector table: running total, including ripple carry, clamp and saturation
    for (int i = 0; i < 15; i++) begin
      run_add(vecs[i].val, vecs[i].total, vecs[i].sat);
    end
    chk("sat_sticky", int'(sat), 1);

    // loadN clears total and flags
    loadN = 1'b0;
    @(posedge clk); #1;
    loadN = 1'b0;
    loadN = 1'b1;
    chk("clear_total", int'({countH, countM, countL}), 0);
    chk("clear_sat", int'(sat), 0);

    // Back-to-back: 0x10, 0x05 into the slot, 0x03 dropped
    e.total = 12'h010; e.sat = 1'b0; sb_q.push_back(e);
    add_req = 1'b1; add_val = 8'h10;
    @(posedge clk); #1;
    e.total = 12'h015; e.sat = 1'b0; sb_q.push_back(e);
    add_val = 8'h05;
    @(posedge clk); #1;
    chk("b2b_busy_t1", int'(busy), 1);
    add_val = 8'h03;
    @(posedge clk); #1;
    add_req = 1'b0;
    chk("b2b_dropped", int'(dropped), 1);
    chk("b2b_busy_t2", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_busy", int'(busy), (i < 3) ? 1 : 0);
      chk("b2b_done", int'(done), (i == 0 || i == 3) ? 1 : 0);
    end
    chk("b2b_total", int'({countH, countM, countL}), 12'h015);

    // loadN together with add_req mid-addition: no commit, everything cleared
    add_req = 1'b1; add_val = 8'h20;
    @(posedge clk); #1;
    loadN = 1'b0;
    @(posedge clk); #1;
    add_req = 1'b0;
    loadN = 1'b1;
    chk("load_total", int'({countH, countM, countL}), 0);
    chk("load_busy", int'(busy), 0);
    chk("load_dropped", int'(dropped), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("load_no_done", int'(done), 0);
    end
    run_add(8'h25, 12'h025, 1'b0);

    // resetN pulsed while in S_T: outputs clear at once, no commit follows
    add_req = 1'b1; add_val = 8'hAF;
    @(posedge clk); #1;
    add_req = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b0;
    #1;
    chk("async_total", int'({countH, countM, countL}), 0);
    chk("async_busy", int'(busy), 0);
    #2;
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("async_no_done", int'(done), 0);
      chk("async_idle", int'(busy), 0);
    end
    run_add(8'hAF, 12'h099, 1'b0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
